random_seq_chk: RTL and testbench
=================================

# random_seq_chk

Receive-side checker for the synthesisable random/linear sequence generator. It regenerates the expected sequence locally from the same parameters and compares every valid beat against it. It reports a sticky fail, a saturating error count, the number of beats checked, and pass/done status. It sits at the read-data end of a NoC/DDR traffic path, facing the generator on the write side.

## Interface
Parameters
- OUTPUT_WIDTH, 32: width of checked data; must match the generator.
- WORD_WIDTH, 8: word size; must be a multiple of 8 and ≤ OUTPUT_WIDTH. Any other value is an elaboration error.
- LINEAR_COUNT, 0: 1 selects linear expected words.
- COUNT_DOWN, 0: 1 selects down-offset linear words. Ignored when LINEAR_COUNT=0.
- FIRST_WORD_LINEAR, 1: 1 makes word 0 an incrementing count.
- INIT_VALUE, all zeros: first expected beat after start.
- ERR_CNT_WIDTH, 16: width of the error counter.
- BEAT_CNT_WIDTH, 32: width of the beat counter and of the beat target.

Ports
- i_clk, in, 1: clock.
- i_reset, in, 1: asynchronous, active-high reset.
- i_start, in, 1: a rising edge restarts the check.
- i_num_beats, in, BEAT_CNT_WIDTH: beats to check. 0 means check forever. Sampled on the start edge.
- i_valid, in, 1: i_data holds a beat to check.
- i_data, in, OUTPUT_WIDTH: received data.
- o_running, out, 1: state is RUN.
- o_done, out, 1: state is DONE.
- o_pass, out, 1: o_done=1 and o_fail=0.
- o_fail, out, 1: sticky mismatch flag.
- o_err_count, out, ERR_CNT_WIDTH: count of mismatched beats; saturates at all-ones.
- o_beat_count, out, BEAT_CNT_WIDTH: count of beats checked.
- o_err_data, out, OUTPUT_WIDTH: first mismatching received beat.
- o_err_expected, out, OUTPUT_WIDTH: expected value for that beat.

## Operation
- Internal width: NUM_WORDS = ceil(OUTPUT_WIDTH/WORD_WIDTH); the internal expected register is NUM_WORDS×WORD_WIDTH bits. Comparison uses the low OUTPUT_WIDTH bits only.
- Next expected value is computed from w0 = current expected word 0. All arithmetic is modulo 2^WORD_WIDTH.
  - With FIRST_WORD_LINEAR=1, word 0 becomes w0+1.
  - Every other word ii (including word 0 when FIRST_WORD_LINEAR=0) is formed as follows.
  - Linear: w0+ii+1, or w0−ii+1 when COUNT_DOWN=1.
  - Random: first take r = rotate-left(w0, (ii+5) mod WORD_WIDTH). The word is r with bit 0 replaced by r[2]^r[4]^r[5]^r[7]; bits W−1:1 are unchanged.
- The expected register advances only on an accepted beat.
- FSM states:
  - IDLE (the reset state): i_valid is ignored.
  - RUN: each i_valid beat is compared.
  - DONE: i_valid is ignored.
- FSM transitions:
  - Start edge, from any state → RUN. The start edge loads the expected register with INIT_VALUE, clears all counters, o_fail and the capture registers, flushes the pipeline, and latches i_num_beats.
  - RUN → DONE when the beat count reaches a nonzero target.
  - DONE → RUN only on a new start edge.
- Start edge = i_start=1 while the registered i_start was 0. The registered i_start resets to 1, so i_start held high through reset produces no edge.
- A beat with i_valid in the same cycle as a start edge is dropped.
- o_err_count saturates at all-ones and does not wrap.
- o_beat_count wraps when the target is 0.

## Timing
- Stage 1: an accepted i_valid at cycle N registers i_data and the current expected value, and advances the expected register.
- Stage 2, cycle N+1: the mismatch flag is registered.
- Cycle N+2: o_fail, o_err_count, o_beat_count and the capture outputs update.
- DONE is entered at N+2 of the final beat; o_done and o_pass are valid at that point.
- Back-to-back beats are accepted every cycle with no stalls.
- Reset values: all outputs 0; state IDLE; expected register = INIT_VALUE.
- Reset asserted mid-run clears everything immediately. A beat in flight is discarded.

## Configuration
- Macro: RANDOM_SEQ_CHK_ERR_CAPTURE_EN.
- Defined: o_err_data and o_err_expected capture the first mismatch after start and hold until the next start or reset.
- Undefined: the capture registers are not built and both outputs are tied to 0. All other behaviour is identical.

## Test plan
- Linear checking, OUTPUT_WIDTH=32, WORD_WIDTH=8, LINEAR_COUNT=1, INIT_VALUE=0, i_num_beats=3.
  - Stimulus: start, then drive 0x00000000, 0x04030201, 0x05040302.
  - Required: o_beat_count=3, o_done=1, o_pass=1, o_err_count=0.
- Corrupted beat, same setup.
  - Stimulus: beat 2 driven as 0x04030211.
  - Required: o_fail=1 two cycles after that beat; o_err_count=1; o_pass=0 at done.
  - With the macro defined: o_err_data=0x04030211 and o_err_expected=0x04030201.
- Random mode (LINEAR_COUNT=0), 1000 beats.
  - Stimulus: loop the generator with the same parameters into the checker, with i_valid toggled at random.
  - Required: o_err_count=0 and o_pass=1.
- Saturation and restart.
  - Stimulus: ERR_CNT_WIDTH=4 with 20 bad beats, then a start edge.
  - Required: o_err_count holds at 15; after the start edge, count and o_fail read 0 and the expected value restarts at INIT_VALUE.
- Edge cases.
  - Stimulus: assert i_valid in the start-edge cycle; separately, assert i_reset during RUN.
  - Required: the start-cycle beat is not counted; reset returns all outputs to 0 and the state to IDLE asynchronously.

Source files
------------

// File: rtl/random_seq_chk_if.sv
// Beat stream carried from the traffic path into the sequence checker.
// Combinational bundle only; no latency of its own.
// No backpressure: the checker accepts a beat on every cycle valid is high.
interface random_seq_chk_if #(
   parameter int OUTPUT_WIDTH = 32
) ();
   logic                    beat_vld;
   logic [OUTPUT_WIDTH-1:0] beat_dat;

   modport master (output beat_vld, output beat_dat);
   modport slave  (input  beat_vld, input  beat_dat);
endinterface

// File: rtl/random_seq_chk.sv
// Receive-side checker: regenerates the random/linear sequence and compares each valid beat.
// Latency: beat sampled at edge N, counters/fail/capture update at edge N+2.
// No backpressure: beats are accepted every cycle; optional capture via RANDOM_SEQ_CHK_ERR_CAPTURE_EN.
module random_seq_chk #(
   parameter int                      OUTPUT_WIDTH      = 32,
   parameter int                      WORD_WIDTH        = 8,
   parameter int                      LINEAR_COUNT      = 0,
   parameter int                      COUNT_DOWN        = 0,
   parameter int                      FIRST_WORD_LINEAR = 1,
   parameter logic [OUTPUT_WIDTH-1:0] INIT_VALUE        = '0,
   parameter int                      ERR_CNT_WIDTH     = 16,
   parameter int                      BEAT_CNT_WIDTH    = 32
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_start,
   input  logic [BEAT_CNT_WIDTH-1:0] i_num_beats,
   random_seq_chk_if.slave           beat_if,
   output logic                      o_running,
   output logic                      o_done,
   output logic                      o_pass,
   output logic                      o_fail,
   output logic [ERR_CNT_WIDTH-1:0]  o_err_count,
   output logic [BEAT_CNT_WIDTH-1:0] o_beat_count,
   output logic [OUTPUT_WIDTH-1:0]   o_err_data,
   output logic [OUTPUT_WIDTH-1:0]   o_err_expected
);

   localparam int NUM_WORDS = (OUTPUT_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
   localparam int EXP_W     = NUM_WORDS * WORD_WIDTH;
   localparam logic [EXP_W-1:0] INIT_EXT = EXP_W'(INIT_VALUE);

   if ((WORD_WIDTH % 8) != 0 || WORD_WIDTH < 8 || WORD_WIDTH > OUTPUT_WIDTH) begin : g_bad_word_width
      $error("random_seq_chk: WORD_WIDTH must be a multiple of 8 and no wider than OUTPUT_WIDTH");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                    state;
   logic                      start_q;
   logic                      start_edge;
   logic                      accept;
   logic [BEAT_CNT_WIDTH-1:0] beat_target;
   logic [BEAT_CNT_WIDTH-1:0] beat_nxt;
   logic                      err_sat;

   logic [EXP_W-1:0]          exp_q;
   logic [EXP_W-1:0]          exp_nxt;
   logic [WORD_WIDTH-1:0]     nx_w0;
   logic [WORD_WIDTH-1:0]     nx_rot;
   logic [WORD_WIDTH-1:0]     nx_word;

   logic                      s1_vld;
   logic [OUTPUT_WIDTH-1:0]   s1_dat;
   logic [OUTPUT_WIDTH-1:0]   s1_exp;
   logic                      s2_vld;
   logic                      s2_mis;

   // start_q resets high so a start held through reset is not seen as an edge
   assign start_edge = i_start & ~start_q;
   // a beat coinciding with a restart belongs to the old run and is dropped
   assign accept     = (state == ST_RUN) && beat_if.beat_vld && !start_edge;
   assign beat_nxt   = o_beat_count + BEAT_CNT_WIDTH'(1);
   assign err_sat    = &o_err_count;

   // Remember last cycle's start level for edge detection
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) start_q <= 1'b1;
      else         start_q <= i_start;
   end

   // Next expected beat, derived entirely from word 0 of the current one
   always_comb begin
      exp_nxt = '0;
      nx_rot  = '0;
      nx_word = '0;
      nx_w0   = exp_q[WORD_WIDTH-1:0];
      for (int ii = 0; ii < NUM_WORDS; ii++) begin
         if (ii == 0 && FIRST_WORD_LINEAR != 0) begin
            nx_word = nx_w0 + WORD_WIDTH'(1);
         end else if (LINEAR_COUNT != 0) begin
            if (COUNT_DOWN != 0) nx_word = nx_w0 - WORD_WIDTH'(ii) + WORD_WIDTH'(1);
            else                 nx_word = nx_w0 + WORD_WIDTH'(ii + 1);
         end else begin
            nx_rot  = (nx_w0 << ((ii + 5) % WORD_WIDTH)) |
                      (nx_w0 >> (WORD_WIDTH - ((ii + 5) % WORD_WIDTH)));
            nx_word = {nx_rot[WORD_WIDTH-1:1], nx_rot[2] ^ nx_rot[4] ^ nx_rot[5] ^ nx_rot[7]};
         end
         exp_nxt[ii*WORD_WIDTH +: WORD_WIDTH] = nx_word;
      end
   end

   // Two-stage compare pipeline; expected value steps only on accepted beats
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         exp_q  <= INIT_EXT;
         s1_vld <= 1'b0;
         s1_dat <= '0;
         s1_exp <= '0;
         s2_vld <= 1'b0;
         s2_mis <= 1'b0;
      end else if (start_edge) begin
         exp_q  <= INIT_EXT;
         s1_vld <= 1'b0;
         s2_vld <= 1'b0;
         s2_mis <= 1'b0;
      end else begin
         s1_vld <= accept;
         if (accept) begin
            s1_dat <= beat_if.beat_dat;
            s1_exp <= exp_q[OUTPUT_WIDTH-1:0];
            exp_q  <= exp_nxt;
         end
         s2_vld <= s1_vld;
         s2_mis <= s1_vld && (s1_dat != s1_exp);
      end
   end

   // Run-control FSM with registered status, counters and sticky fail
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state        <= ST_IDLE;
         beat_target  <= '0;
         o_running    <= 1'b0;
         o_done       <= 1'b0;
         o_pass       <= 1'b0;
         o_fail       <= 1'b0;
         o_err_count  <= '0;
         o_beat_count <= '0;
      end else if (start_edge) begin
         state        <= ST_RUN;
         beat_target  <= i_num_beats;
         o_running    <= 1'b1;
         o_done       <= 1'b0;
         o_pass       <= 1'b0;
         o_fail       <= 1'b0;
         o_err_count  <= '0;
         o_beat_count <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (s2_vld) begin
                  o_beat_count <= beat_nxt;
                  if (s2_mis) begin
                     o_fail <= 1'b1;
                     if (!err_sat) o_err_count <= o_err_count + ERR_CNT_WIDTH'(1);
                  end
                  if (beat_target != '0 && beat_nxt == beat_target) begin
                     state     <= ST_DONE;
                     o_running <= 1'b0;
                     o_done    <= 1'b1;
                     o_pass    <= !(o_fail || s2_mis);
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef RANDOM_SEQ_CHK_ERR_CAPTURE_EN
   logic [OUTPUT_WIDTH-1:0] s2_dat;
   logic [OUTPUT_WIDTH-1:0] s2_exp;

   // Carry the compared pair alongside the mismatch flag
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         s2_dat <= '0;
         s2_exp <= '0;
      end else begin
         s2_dat <= s1_dat;
         s2_exp <= s1_exp;
      end
   end

   // Hold the first mismatching beat of the run (o_fail still low marks it as first)
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_err_data     <= '0;
         o_err_expected <= '0;
      end else if (start_edge) begin
         o_err_data     <= '0;
         o_err_expected <= '0;
      end else if (state == ST_RUN && s2_vld && s2_mis && !o_fail) begin
         o_err_data     <= s2_dat;
         o_err_expected <= s2_exp;
      end
   end
`else
   assign o_err_data     = '0;
   assign o_err_expected = '0;
`endif

endmodule

// File: tb/tb_random_seq_chk.sv
// Directed bench for random_seq_chk: a linear checker (4-bit error count) and a random checker.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected values are hand-computed; the long random run uses a byte-rotation model.
module tb_random_seq_chk;

   logic        i_clk;
   logic        i_reset;

   logic        lin_start;
   logic [31:0] lin_num;
   logic        lin_running, lin_done, lin_pass, lin_fail;
   logic [3:0]  lin_err;
   logic [31:0] lin_beats, lin_err_data, lin_err_exp;

   logic        rnd_start;
   logic [31:0] rnd_num;
   logic        rnd_running, rnd_done, rnd_pass, rnd_fail;
   logic [15:0] rnd_err;
   logic [31:0] rnd_beats, rnd_err_data, rnd_err_exp;

   int checks = 0;
   int errors = 0;

   random_seq_chk_if #(.OUTPUT_WIDTH(32)) lin_if ();
   random_seq_chk_if #(.OUTPUT_WIDTH(32)) rnd_if ();

   random_seq_chk #(
      .OUTPUT_WIDTH(32), .WORD_WIDTH(8), .LINEAR_COUNT(1), .COUNT_DOWN(0),
      .FIRST_WORD_LINEAR(1), .INIT_VALUE(32'h0), .ERR_CNT_WIDTH(4), .BEAT_CNT_WIDTH(32)
   ) u_lin (
      .i_clk(i_clk), .i_reset(i_reset), .i_start(lin_start), .i_num_beats(lin_num),
      .beat_if(lin_if), .o_running(lin_running), .o_done(lin_done), .o_pass(lin_pass),
      .o_fail(lin_fail), .o_err_count(lin_err), .o_beat_count(lin_beats),
      .o_err_data(lin_err_data), .o_err_expected(lin_err_exp)
   );

   random_seq_chk #(
      .OUTPUT_WIDTH(32), .WORD_WIDTH(8), .LINEAR_COUNT(0), .COUNT_DOWN(0),
      .FIRST_WORD_LINEAR(1), .INIT_VALUE(32'h0), .ERR_CNT_WIDTH(16), .BEAT_CNT_WIDTH(32)
   ) u_rnd (
      .i_clk(i_clk), .i_reset(i_reset), .i_start(rnd_start), .i_num_beats(rnd_num),
      .beat_if(rnd_if), .o_running(rnd_running), .o_done(rnd_done), .o_pass(rnd_pass),
      .o_fail(rnd_fail), .o_err_count(rnd_err), .o_beat_count(rnd_beats),
      .o_err_data(rnd_err_data), .o_err_expected(rnd_err_exp)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Random-mode successor: word 0 increments, word k is rotl(w0, k+5) with bit 0 re-derived
   function automatic logic [31:0] rnd_model(input logic [31:0] cur);
      logic [7:0]  b;
      logic [15:0] two;
      logic [7:0]  r;
      logic [31:0] res;
      b = cur[7:0];
      res = '0;
      res[7:0] = b + 8'd1;
      for (int k = 1; k < 4; k++) begin
         two = {b, b} << ((k + 5) % 8);
         r = two[15:8];
         r[0] = r[2] ^ r[4] ^ r[5] ^ r[7];
         res[k*8 +: 8] = r;
      end
      return res;
   endfunction

   // All stimulus tasks start and end on a falling edge
   task automatic lin_go(input logic [31:0] n);
      lin_start = 1'b1; lin_num = n;
      @(negedge i_clk);
      lin_start = 1'b0;
   endtask

   task automatic lin_beat(input logic [31:0] d);
      lin_if.beat_vld = 1'b1; lin_if.beat_dat = d;
      @(negedge i_clk);
   endtask

   task automatic lin_idle(input int n);
      lin_if.beat_vld = 1'b0;
      repeat (n) @(negedge i_clk);
   endtask

   task automatic rnd_go(input logic [31:0] n);
      rnd_start = 1'b1; rnd_num = n;
      @(negedge i_clk);
      rnd_start = 1'b0;
   endtask

   task automatic rnd_beat(input logic [31:0] d);
      rnd_if.beat_vld = 1'b1; rnd_if.beat_dat = d;
      @(negedge i_clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge i_clk);
      checks++; if (lin_running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", lin_running); end
      checks++; if (lin_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", lin_done); end
      checks++; if (lin_pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b want 0", lin_pass); end
      checks++; if (lin_fail !== 1'b0) begin errors++; $display("FAIL reset_fail: got %b want 0", lin_fail); end
      checks++; if (lin_err !== 4'd0) begin errors++; $display("FAIL reset_err: got %0d want 0", lin_err); end
      checks++; if (lin_beats !== 32'd0) begin errors++; $display("FAIL reset_beats: got %0d want 0", lin_beats); end
      checks++; if (lin_err_data !== 32'd0) begin errors++; $display("FAIL reset_err_data: got %h want 0", lin_err_data); end
      checks++; if (rnd_err !== 16'd0) begin errors++; $display("FAIL reset_rnd_err: got %0d want 0", rnd_err); end
      i_reset = 1'b0;
      repeat (3) @(negedge i_clk);
      checks++; if (lin_running !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got %b want 0", lin_running); end
   endtask

   task automatic test_linear();
      lin_go(32'd3);
      checks++; if (lin_running !== 1'b1) begin errors++; $display("FAIL lin_running: got %b want 1", lin_running); end
      lin_beat(32'h00000000);
      lin_beat(32'h04030201);
      lin_beat(32'h05040302);
      lin_idle(2);
      checks++; if (lin_beats !== 32'd3) begin errors++; $display("FAIL lin_beats: got %0d want 3", lin_beats); end
      checks++; if (lin_done !== 1'b1) begin errors++; $display("FAIL lin_done: got %b want 1", lin_done); end
      checks++; if (lin_pass !== 1'b1) begin errors++; $display("FAIL lin_pass: got %b want 1", lin_pass); end
      checks++; if (lin_err !== 4'd0) begin errors++; $display("FAIL lin_err: got %0d want 0", lin_err); end
      checks++; if (lin_running !== 1'b0) begin errors++; $display("FAIL lin_running_done: got %b want 0", lin_running); end
   endtask

   task automatic test_corrupt();
      lin_go(32'd3);
      checks++; if (lin_done !== 1'b0 || lin_beats !== 32'd0) begin errors++; $display("FAIL bad_restart: done %b beats %0d want 0 0", lin_done, lin_beats); end
      lin_beat(32'h00000000);
      lin_beat(32'h04030211);
      lin_beat(32'h05040302);
      checks++; if (lin_fail !== 1'b0) begin errors++; $display("FAIL bad_fail_early: got %b want 0", lin_fail); end
      lin_idle(1);
      checks++; if (lin_fail !== 1'b1) begin errors++; $display("FAIL bad_fail_n2: got %b want 1", lin_fail); end
      checks++; if (lin_err !== 4'd1) begin errors++; $display("FAIL bad_err_n2: got %0d want 1", lin_err); end
      checks++; if (lin_done !== 1'b0) begin errors++; $display("FAIL bad_done_early: got %b want 0", lin_done); end
      lin_idle(1);
      checks++; if (lin_done !== 1'b1) begin errors++; $display("FAIL bad_done: got %b want 1", lin_done); end
      checks++; if (lin_pass !== 1'b0) begin errors++; $display("FAIL bad_pass: got %b want 0", lin_pass); end
      checks++; if (lin_err !== 4'd1) begin errors++; $display("FAIL bad_err: got %0d want 1", lin_err); end
`ifdef RANDOM_SEQ_CHK_ERR_CAPTURE_EN
      checks++; if (lin_err_data !== 32'h04030211) begin errors++; $display("FAIL cap_data: got %h want 04030211", lin_err_data); end
      checks++; if (lin_err_exp !== 32'h04030201) begin errors++; $display("FAIL cap_exp: got %h want 04030201", lin_err_exp); end
`else
      checks++; if (lin_err_data !== 32'h0) begin errors++; $display("FAIL cap_data_off: got %h want 0", lin_err_data); end
      checks++; if (lin_err_exp !== 32'h0) begin errors++; $display("FAIL cap_exp_off: got %h want 0", lin_err_exp); end
`endif
   endtask

   task automatic test_random();
      logic [31:0] cur;
      int          sent;
      rnd_go(32'd4);
      rnd_beat(32'h00000000);
      rnd_beat(32'h00000001);
      rnd_beat(32'h00814002);
      rnd_beat(32'h02008103);
      rnd_if.beat_vld = 1'b0;
      repeat (2) @(negedge i_clk);
      checks++; if (rnd_done !== 1'b1 || rnd_pass !== 1'b1) begin errors++; $display("FAIL rnd_short: done %b pass %b want 1 1", rnd_done, rnd_pass); end
      checks++; if (rnd_beats !== 32'd4) begin errors++; $display("FAIL rnd_short_beats: got %0d want 4", rnd_beats); end
      rnd_go(32'd1000);
      cur  = 32'h0;
      sent = 0;
      for (int cyc = 0; cyc < 5000 && sent < 1000; cyc++) begin
         if ($urandom_range(0, 1) == 1) begin
            rnd_if.beat_vld = 1'b1; rnd_if.beat_dat = cur;
            cur = rnd_model(cur);
            sent++;
         end else begin
            rnd_if.beat_vld = 1'b0; rnd_if.beat_dat = 32'hA5A5A5A5;
         end
         @(negedge i_clk);
      end
      rnd_if.beat_vld = 1'b0;
      for (int cyc = 0; cyc < 10 && rnd_done !== 1'b1; cyc++) @(negedge i_clk);
      checks++; if (rnd_done !== 1'b1) begin errors++; $display("FAIL rnd_done: got %b want 1 (sent %0d)", rnd_done, sent); end
      checks++; if (rnd_err !== 16'd0) begin errors++; $display("FAIL rnd_err: got %0d want 0", rnd_err); end
      checks++; if (rnd_pass !== 1'b1) begin errors++; $display("FAIL rnd_pass: got %b want 1", rnd_pass); end
      checks++; if (rnd_beats !== 32'd1000) begin errors++; $display("FAIL rnd_beats: got %0d want 1000", rnd_beats); end
   endtask

   task automatic test_saturation();
      lin_go(32'd0);
      for (int i = 0; i < 20; i++) lin_beat(32'hFFFFFFFF);
      lin_idle(2);
      checks++; if (lin_err !== 4'd15) begin errors++; $display("FAIL sat_err: got %0d want 15", lin_err); end
      checks++; if (lin_fail !== 1'b1) begin errors++; $display("FAIL sat_fail: got %b want 1", lin_fail); end
      checks++; if (lin_beats !== 32'd20) begin errors++; $display("FAIL sat_beats: got %0d want 20", lin_beats); end
      checks++; if (lin_running !== 1'b1 || lin_done !== 1'b0) begin errors++; $display("FAIL sat_forever: running %b done %b want 1 0", lin_running, lin_done); end
      lin_go(32'd1);
      checks++; if (lin_err !== 4'd0 || lin_fail !== 1'b0) begin errors++; $display("FAIL restart_clear: err %0d fail %b want 0 0", lin_err, lin_fail); end
      checks++; if (lin_beats !== 32'd0) begin errors++; $display("FAIL restart_beats: got %0d want 0", lin_beats); end
      lin_beat(32'h00000000);
      lin_idle(2);
      checks++; if (lin_pass !== 1'b1) begin errors++; $display("FAIL restart_init: pass got %b want 1", lin_pass); end
   endtask

   task automatic test_start_cycle_beat();
      lin_go(32'd0);
      lin_idle(1);
      lin_if.beat_vld = 1'b1; lin_if.beat_dat = 32'hDEADBEEF;
      lin_go(32'd2);
      lin_beat(32'h00000000);
      lin_beat(32'h04030201);
      lin_idle(2);
      checks++; if (lin_beats !== 32'd2) begin errors++; $display("FAIL start_beat_count: got %0d want 2", lin_beats); end
      checks++; if (lin_pass !== 1'b1 || lin_err !== 4'd0) begin errors++; $display("FAIL start_beat_pass: pass %b err %0d want 1 0", lin_pass, lin_err); end
   endtask

   task automatic test_reset_midrun();
      lin_go(32'd0);
      lin_beat(32'h00000000);
      lin_beat(32'h00000BAD);
      lin_idle(1);
      checks++; if (lin_beats !== 32'd1 || lin_fail !== 1'b0) begin errors++; $display("FAIL pre_reset: beats %0d fail %b want 1 0", lin_beats, lin_fail); end
      lin_start = 1'b1;
      #2 i_reset = 1'b1;
      #1;
      checks++; if (lin_running !== 1'b0) begin errors++; $display("FAIL async_running: got %b want 0", lin_running); end
      checks++; if (lin_beats !== 32'd0) begin errors++; $display("FAIL async_beats: got %0d want 0", lin_beats); end
      checks++; if (lin_done !== 1'b0 || lin_pass !== 1'b0 || lin_err !== 4'd0) begin errors++; $display("FAIL async_status: done %b pass %b err %0d want 0", lin_done, lin_pass, lin_err); end
      repeat (2) @(negedge i_clk);
      i_reset = 1'b0;
      repeat (4) @(negedge i_clk);
      checks++; if (lin_running !== 1'b0) begin errors++; $display("FAIL held_start_edge: running %b want 0", lin_running); end
      checks++; if (lin_fail !== 1'b0 || lin_beats !== 32'd0) begin errors++; $display("FAIL inflight_dropped: fail %b beats %0d want 0 0", lin_fail, lin_beats); end
      lin_start = 1'b0;
   endtask

   initial begin
      i_reset = 1'b1;
      lin_start = 1'b0; lin_num = '0; lin_if.beat_vld = 1'b0; lin_if.beat_dat = '0;
      rnd_start = 1'b0; rnd_num = '0; rnd_if.beat_vld = 1'b0; rnd_if.beat_dat = '0;
      test_reset();
      test_linear();
      test_corrupt();
      test_random();
      test_saturation();
      test_start_cycle_beat();
      test_reset_midrun();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
